// File: rtl/gradient_magnitude_if.sv
// Stream bundle for gradient_magnitude: Gx/Gy input beats, magnitude output beats, frame stats.
interface gradient_magnitude_if #(
    parameter int unsigned WIDTH_P = 8,
    parameter int unsigned CNT_W_P = 20
);
    logic               valid_i;
    logic               ready_o;
    logic [WIDTH_P-1:0] gx_i;
    logic [WIDTH_P-1:0] gy_i;
    logic               mode_i;
    logic               last_i;
    logic [WIDTH_P-1:0] thresh_i;
    logic               valid_o;
    logic               ready_i;
    logic [WIDTH_P-1:0] mag_o;
    logic               last_o;
    logic [CNT_W_P-1:0] edge_count_o;
    logic               count_valid_o;

    modport master (
        output valid_i, gx_i, gy_i, mode_i, last_i, thresh_i, ready_i,
        input  ready_o, valid_o, mag_o, last_o, edge_count_o, count_valid_o
    );

    modport slave (
        input  valid_i, gx_i, gy_i, mode_i, last_i, thresh_i, ready_i,
        output ready_o, valid_o, mag_o, last_o, edge_count_o, count_valid_o
    );
endinterface

// File: rtl/gradient_magnitude.sv
// Two-stage gradient magnitude (L1 or alpha-max-beta-min L2), saturated and thresholded.
// Define GRADIENT_MAGNITUDE_STATS_EN to build the per-frame nonzero-pixel counter.
module gradient_magnitude #(
    parameter int unsigned WIDTH_P = 8,
    parameter int unsigned CNT_W_P = 20
) (
    input logic                  clk_i,
    input logic                  rst_i,
    gradient_magnitude_if.slave  bus
);
    logic               en1, en2;
    logic               v1_q, v1_d, v2_q, v2_d;
    logic [WIDTH_P-1:0] ax_q, ax_d, ay_q, ay_d;
    logic               mode1_q, mode1_d, last1_q, last1_d;
    logic [WIDTH_P-1:0] mag_q, mag_d;
    logic               last2_q, last2_d;
    logic [WIDTH_P-1:0] hi, lo, sat;
    logic [WIDTH_P:0]   sum;

    // Unsigned result, so |-2^(W-1)| = 2^(W-1) fits without wrapping.
    function automatic logic [WIDTH_P-1:0] abs_val(input logic [WIDTH_P-1:0] v);
        return v[WIDTH_P-1] ? (~v + WIDTH_P'(1)) : v;
    endfunction

    always_comb begin
        en2 = !v2_q || bus.ready_i;
        en1 = !v1_q || en2;

        v1_d    = v1_q;
        ax_d    = ax_q;
        ay_d    = ay_q;
        mode1_d = mode1_q;
        last1_d = last1_q;
        if (en1) begin
            v1_d    = bus.valid_i;
            ax_d    = abs_val(bus.gx_i);
            ay_d    = abs_val(bus.gy_i);
            mode1_d = bus.mode_i;
            last1_d = bus.last_i;
        end

        hi  = (ax_q >= ay_q) ? ax_q : ay_q;
        lo  = (ax_q >= ay_q) ? ay_q : ax_q;
        sum = mode1_q ? ({1'b0, hi} + {2'b00, lo[WIDTH_P-1:1]})
                      : ({1'b0, ax_q} + {1'b0, ay_q});
        sat = sum[WIDTH_P] ? '1 : sum[WIDTH_P-1:0];

        v2_d    = v2_q;
        mag_d   = mag_q;
        last2_d = last2_q;
        if (en2) begin
            v2_d    = v1_q;
            mag_d   = (sat >= bus.thresh_i) ? sat : '0;
            last2_d = last1_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1_q    <= 1'b0;
            ax_q    <= '0;
            ay_q    <= '0;
            mode1_q <= 1'b0;
            last1_q <= 1'b0;
            v2_q    <= 1'b0;
            mag_q   <= '0;
            last2_q <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            ax_q    <= ax_d;
            ay_q    <= ay_d;
            mode1_q <= mode1_d;
            last1_q <= last1_d;
            v2_q    <= v2_d;
            mag_q   <= mag_d;
            last2_q <= last2_d;
        end
    end

    // Forced high in reset: anything offered then is discarded by the reset edge.
    assign bus.ready_o = en1 | rst_i;
    assign bus.valid_o = v2_q;
    assign bus.mag_o   = mag_q;
    assign bus.last_o  = last2_q;

`ifdef GRADIENT_MAGNITUDE_STATS_EN
    logic               fire_out, nz;
    logic [CNT_W_P-1:0] cnt_q, cnt_d, edge_cnt_q, edge_cnt_d;
    logic               cv_q, cv_d;

    always_comb begin
        fire_out   = v2_q && bus.ready_i;
        nz         = |mag_q;
        cnt_d      = cnt_q;
        edge_cnt_d = edge_cnt_q;
        cv_d       = 1'b0;
        if (fire_out) begin
            if (last2_q) begin
                edge_cnt_d = (nz && (cnt_q != '1)) ? cnt_q + CNT_W_P'(1) : cnt_q;
                cnt_d      = '0;
                cv_d       = 1'b1;
            end else if (nz && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W_P'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            edge_cnt_q <= '0;
            cv_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            edge_cnt_q <= edge_cnt_d;
            cv_q       <= cv_d;
        end
    end

    assign bus.edge_count_o  = edge_cnt_q;
    assign bus.count_valid_o = cv_q;
`else
    assign bus.edge_count_o  = '0;
    assign bus.count_valid_o = 1'b0;
`endif
endmodule

// File: tb/tb_gradient_magnitude.sv
// Scoreboard bench for gradient_magnitude: directed test-plan beats plus randomized traffic.
module tb_gradient_magnitude;
`ifdef GRADIENT_MAGNITUDE_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    typedef struct {
        logic [7:0] gx;
        logic [7:0] gy;
        bit         mode;
        bit         last;
        int         exp;
    } stim_t;

    typedef struct {
        int mag;
        bit last;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    total = 0;
    int    bad = 0;
    stim_t stim_q[$];
    exp_t  exp_q[$];
    bit    rand_ready = 1'b0;
    bit    force_ready = 1'b1;
    bit    bubbles = 1'b0;

    gradient_magnitude_if #(.WIDTH_P(8), .CNT_W_P(20)) bus ();

    gradient_magnitude #(.WIDTH_P(8), .CNT_W_P(20)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, wanted %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic straight from the magnitude rules.
    function automatic int ref_mag(input logic [7:0] gx, input logic [7:0] gy,
                                   input bit mode, input int th);
        int a, b, hi, lo, s;
        a = int'($signed(gx));
        b = int'($signed(gy));
        if (a < 0) a = -a;
        if (b < 0) b = -b;
        hi = (a > b) ? a : b;
        lo = (a > b) ? b : a;
        s  = mode ? hi + lo / 2 : a + b;
        if (s > 255) s = 255;
        return (s >= th) ? s : 0;
    endfunction

    task automatic push(input int gx, input int gy, input bit mode, input bit last, input int exp);
        stim_t s;
        s.gx   = 8'(gx);
        s.gy   = 8'(gy);
        s.mode = mode;
        s.last = last;
        s.exp  = exp;
        stim_q.push_back(s);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((stim_q.size() != 0 || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d beats still pending after %0d cycles",
                     stim_q.size() + exp_q.size(), n);
        end
        repeat (3) @(negedge clk);
    endtask

    // Input driver: expected response is queued at the input transfer.
    initial begin
        stim_t s;
        exp_t  e;
        bus.valid_i = 1'b0;
        bus.gx_i    = '0;
        bus.gy_i    = '0;
        bus.mode_i  = 1'b0;
        bus.last_i  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && bus.valid_i && bus.ready_o && stim_q.size() > 0) begin
                s      = stim_q.pop_front();
                e.mag  = (s.exp >= 0) ? s.exp : ref_mag(s.gx, s.gy, s.mode, int'(bus.thresh_i));
                e.last = s.last;
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
            if (stim_q.size() > 0 && !(bubbles && $urandom_range(0, 3) == 0)) begin
                bus.valid_i = 1'b1;
                bus.gx_i    = stim_q[0].gx;
                bus.gy_i    = stim_q[0].gy;
                bus.mode_i  = stim_q[0].mode;
                bus.last_i  = stim_q[0].last;
            end else begin
                bus.valid_i = 1'b0;
                bus.gx_i    = 8'($urandom);
                bus.gy_i    = 8'($urandom);
                bus.mode_i  = 1'($urandom);
                bus.last_i  = 1'($urandom);
            end
        end
    end

    initial begin
        bus.ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : force_ready;
        end
    end

    // Monitor: pops the scoreboard on output transfers, tracks stalls and frame counts.
    initial begin
        exp_t e;
        int   model_cnt = 0;
        int   exp_edge = 0;
        bit   pulse_pending = 1'b0;
        bit   hold_valid = 1'b0;
        int   hold_mag = 0;
        bit   hold_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                model_cnt     = 0;
                exp_edge      = 0;
                pulse_pending = 1'b0;
                hold_valid    = 1'b0;
                continue;
            end
            check("count_valid_o", bus.count_valid_o, pulse_pending);
            check("edge_count_o", bus.edge_count_o, exp_edge);
            pulse_pending = 1'b0;
            if (hold_valid) begin
                check("stall_valid_o", bus.valid_o, 1);
                check("stall_mag_o", bus.mag_o, hold_mag);
                check("stall_last_o", bus.last_o, hold_last);
            end
            hold_valid = 1'b0;
            if (bus.valid_o && bus.ready_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: mag_o=%0d with no beat pending", bus.mag_o);
                end else begin
                    e = exp_q.pop_front();
                    check("mag_o", bus.mag_o, e.mag);
                    check("last_o", bus.last_o, e.last);
                    if (StatsEn) begin
                        if (e.last) begin
                            exp_edge      = model_cnt + ((e.mag != 0) ? 1 : 0);
                            if (exp_edge > 20'hFFFFF) exp_edge = 20'hFFFFF;
                            model_cnt     = 0;
                            pulse_pending = 1'b1;
                        end else if (e.mag != 0 && model_cnt < 20'hFFFFF) begin
                            model_cnt++;
                        end
                    end
                end
            end else if (bus.valid_o) begin
                hold_valid = 1'b1;
                hold_mag   = int'(bus.mag_o);
                hold_last  = bus.last_o;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.thresh_i = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid_o", bus.valid_o, 0);
        check("rst_mag_o", bus.mag_o, 0);
        check("rst_last_o", bus.last_o, 0);
        check("rst_edge_count_o", bus.edge_count_o, 0);
        check("rst_count_valid_o", bus.count_valid_o, 0);
        check("rst_ready_o", bus.ready_o, 1);
        @(posedge clk);
        #2 rst = 1'b0;

        // Stats frame: mags 0,10,0,200,5, then a second frame 7,0,9.
        push(0, 0, 0, 0, 0);
        push(6, 4, 0, 0, 10);
        push(0, 0, 0, 0, 0);
        push(100, 100, 0, 0, 200);
        push(2, 3, 0, 1, 5);
        wait_drain();
        check("frame1_edge_count", bus.edge_count_o, StatsEn ? 3 : 0);
        push(7, 0, 0, 0, 7);
        push(0, 0, 0, 0, 0);
        push(-9, 0, 0, 1, 9);
        wait_drain();
        check("frame2_edge_count", bus.edge_count_o, StatsEn ? 2 : 0);

        // Latency on an empty pipeline.
        push(-3, 4, 0, 0, 7);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.valid_i && bus.ready_o) && n < 50);
        check("latency_fire_seen", n < 50, 1);
        @(negedge clk);
        check("latency_cycle1_valid_o", bus.valid_o, 0);
        @(negedge clk);
        check("latency_cycle2_valid_o", bus.valid_o, 1);
        check("latency_cycle2_mag_o", bus.mag_o, 7);

        push(-128, -128, 0, 0, 255);
        push(100, -40, 1, 0, 120);
        push(-128, 127, 1, 0, 191);
        push(10, 4, 0, 0, 14);
        push(10, 4, 1, 0, 12);
        push(10, 4, 0, 0, 14);
        push(10, 4, 1, 0, 12);
        wait_drain();

        bus.thresh_i = 8'd100;
        push(50, 49, 0, 0, 0);
        push(50, 50, 0, 0, 100);
        push(-60, -60, 0, 1, 120);
        wait_drain();
        bus.thresh_i = 8'd0;

        // Stall: downstream blocked while six beats are offered.
        force_ready = 1'b0;
        for (int i = 1; i <= 6; i++) push(i * 10, i * 5, 0, i == 6, i * 15);
        repeat (5) @(negedge clk);
        check("stall_ready_o_low", bus.ready_o, 0);
        check("stall_holds_valid", bus.valid_o, 1);
        force_ready = 1'b1;
        wait_drain();

        // Reset with two beats in flight.
        force_ready = 1'b0;
        push(40, 40, 0, 0, 80);
        push(30, 30, 0, 0, 60);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2;
        stim_q.delete();
        rst = 1'b1;
        @(negedge clk);
        check("reset_ready_o", bus.ready_o, 1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        force_ready = 1'b1;
        @(negedge clk);
        check("post_reset_valid_o", bus.valid_o, 0);
        check("post_reset_count_valid_o", bus.count_valid_o, 0);
        push(5, 0, 0, 0, 5);
        push(0, 0, 0, 0, 0);
        push(3, 3, 1, 1, 4);
        wait_drain();
        check("post_reset_edge_count", bus.edge_count_o, StatsEn ? 2 : 0);

        // Randomized traffic with random backpressure, bubbles and thresholds.
        rand_ready = 1'b1;
        bubbles    = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bus.thresh_i = (c == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            for (int k = 0; k < 60; k++) begin
                push(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     1'($urandom), $urandom_range(0, 15) == 0, -1);
            end
            wait_drain();
        end
        rand_ready = 1'b0;
        bubbles    = 1'b0;
        push(1, 1, 0, 1, -1);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
